// File: rtl/puf_scan_auth_seq.sv
// PUF-gated scan-authorisation sequencer: runs NCH challenge/response rounds, folds the
// responses into n_auth, then opens a scan_enable window of l_scan cycles starting at count n_auth.
module puf_scan_auth_seq #(
    parameter int W       = 16,
    parameter int NCH     = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     seed,
    input  logic [3:0]       activation,
    input  logic [CNT_W-1:0] l_scan,
    output logic             puf_req,
    output logic [W-1:0]     puf_challenge,
    output logic [3:0]       puf_activation,
    input  logic             puf_ack,
    input  logic [W-1:0]     puf_response,
    output logic [W-1:0]     n_auth,
    output logic             n_valid,
    output logic [CNT_W-1:0] current_count,
    output logic             scan_enable,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int KW = $clog2(NCH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_CONV,
        S_COUNT,
        S_DONE
    } state_t;

    typedef logic [CNT_W:0] cnt_t;

    state_t         state;
    logic [W-1:0]   seed_q;
    logic [CNT_W-1:0] lscan_q;
    logic [W-1:0]   acc;
    logic [KW-1:0]  k;
    logic [TW-1:0]  wait_cnt;
    cnt_t           cnt;

    cnt_t n_ext;
    cnt_t win_end;
    cnt_t last_cnt;
    cnt_t cnt_nxt;
    logic se_nxt;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input logic [KW-1:0] sh);
        logic [2*W-1:0] d;
        int m;
        m = int'(sh) % W;
        d = {v, v} << m;
        return d[2*W-1:W];
    endfunction

    // Window arithmetic is one bit wider than the counter so n_auth + l_scan never wraps.
    always_comb begin
        n_ext    = cnt_t'(n_auth);
        win_end  = n_ext + cnt_t'(lscan_q);
        last_cnt = (lscan_q == '0) ? n_ext : win_end - cnt_t'(1);
        cnt_nxt  = cnt + cnt_t'(1);
        se_nxt   = (cnt_nxt >= n_ext) && (cnt_nxt < win_end);
    end

    assign current_count = cnt[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            seed_q         <= '0;
            lscan_q        <= '0;
            acc            <= '0;
            k              <= '0;
            wait_cnt       <= '0;
            cnt            <= '0;
            puf_req        <= 1'b0;
            puf_challenge  <= '0;
            puf_activation <= '0;
            n_auth         <= '0;
            n_valid        <= 1'b0;
            scan_enable    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != S_IDLE && abort) begin
                state       <= S_IDLE;
                puf_req     <= 1'b0;
                scan_enable <= 1'b0;
                n_valid     <= 1'b0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            seed_q         <= seed;
                            puf_activation <= activation;
                            lscan_q        <= l_scan;
                            acc            <= '0;
                            k              <= '0;
                            wait_cnt       <= '0;
                            cnt            <= '0;
                            n_valid        <= 1'b0;
                            error          <= 1'b0;
                            puf_challenge  <= seed;
                            puf_req        <= 1'b1;
                            busy           <= 1'b1;
                            state          <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        // An ack in the final allowed cycle still counts; timeout only without ack.
                        if (puf_ack) begin
                            acc     <= acc ^ puf_response;
                            k       <= k + KW'(1);
                            puf_req <= 1'b0;
                            state   <= S_GAP;
                        end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                            error   <= 1'b1;
                            n_valid <= 1'b0;
                            puf_req <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            wait_cnt <= wait_cnt + TW'(1);
                        end
                    end
                    S_GAP: begin
                        if (k < KW'(NCH)) begin
                            puf_req       <= 1'b1;
                            puf_challenge <= rotl(seed_q, k);
                            wait_cnt      <= '0;
                            state         <= S_REQ;
                        end else begin
                            state <= S_CONV;
                        end
                    end
                    S_CONV: begin
                        n_auth      <= (acc == '0) ? W'(1) : acc;
                        n_valid     <= 1'b1;
                        cnt         <= '0;
                        scan_enable <= 1'b0;
                        state       <= S_COUNT;
                    end
                    S_COUNT: begin
                        if (cnt == last_cnt) begin
                            scan_enable <= 1'b0;
                            done        <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            cnt         <= cnt_nxt;
                            scan_enable <= se_nxt;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_puf_scan_auth_seq.sv
// Bench for puf_scan_auth_seq: table-driven runs, random runs against a run-level model,
// and hand sequences for abort, reset and start-ignore corner cases.
module tb_puf_scan_auth_seq;

    localparam int W       = 16;
    localparam int NCH     = 4;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 64;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [W-1:0]     seed;
    logic [3:0]       activation;
    logic [CNT_W-1:0] l_scan;
    logic             puf_req;
    logic [W-1:0]     puf_challenge;
    logic [3:0]       puf_activation;
    logic             puf_ack;
    logic [W-1:0]     puf_response;
    logic [W-1:0]     n_auth;
    logic             n_valid;
    logic [CNT_W-1:0] current_count;
    logic             scan_enable;
    logic             busy;
    logic             done;
    logic             error;

    puf_scan_auth_seq #(.W(W), .NCH(NCH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seed(seed),
        .activation(activation), .l_scan(l_scan), .puf_req(puf_req),
        .puf_challenge(puf_challenge), .puf_activation(puf_activation),
        .puf_ack(puf_ack), .puf_response(puf_response), .n_auth(n_auth),
        .n_valid(n_valid), .current_count(current_count), .scan_enable(scan_enable),
        .busy(busy), .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rotl_m(input logic [15:0] s, input int k);
        logic [31:0] t;
        t = {s, s} << k;
        return t[31:16];
    endfunction

    task automatic chk_zero(input string name);
        chk(name, {puf_req, puf_challenge, puf_activation, n_auth, n_valid, current_count,
                   scan_enable, busy, done, error}, 64'd0);
    endtask

    // Per-run PUF behaviour: response and ack latency (cycles of puf_req before ack).
    logic [15:0] r_rsp[NCH];
    int          r_dly[NCH];
    bit          r_inject;

    task automatic run_auth(input string name, input logic [15:0] sd, input logic [3:0] act,
                            input logic [15:0] ls);
        int hang, cyc_exp, fin, n_exp, ncha_exp, scan_exp;
        int c, ncha, idx, age, nscan, se_bad, done_c, cc;
        logic [15:0] x;
        bit prev_req, injected, exp_se;
        hang = -1; x = '0; cyc_exp = 0; fin = 0; n_exp = 0;
        for (int i = 0; i < NCH; i++) begin
            if (hang < 0) begin
                if (r_dly[i] >= TIMEOUT) hang = i;
                else begin
                    x = x ^ r_rsp[i];
                    cyc_exp += r_dly[i] + 2;
                end
            end
        end
        if (hang >= 0) begin
            cyc_exp += TIMEOUT + 1;
            ncha_exp = hang + 1;
            scan_exp = 0;
        end else begin
            n_exp = (x == 16'd0) ? 1 : int'(x);
            fin = (ls == 16'd0) ? n_exp : n_exp + int'(ls) - 1;
            cyc_exp += 1 + (fin + 1) + 1;
            ncha_exp = NCH;
            scan_exp = int'(ls);
        end

        start = 1'b1; seed = sd; activation = act; l_scan = ls;
        step();
        start = 1'b0;
        seed = 16'($urandom); activation = 4'($urandom); l_scan = 16'($urandom);
        c = 1; ncha = 0; idx = 0; age = 0; nscan = 0; se_bad = 0; done_c = -1;
        prev_req = 1'b0; injected = 1'b0;
        while (1) begin
            if (c == 1)
                chk({name, ":first_cycle"}, {puf_activation, error, n_valid, busy},
                    {act, 1'b0, 1'b0, 1'b1});
            if (puf_req && !prev_req) begin
                if (ncha < NCH)
                    chk($sformatf("%s:chal%0d", name, ncha), puf_challenge, rotl_m(sd, ncha));
                idx = ncha; ncha++; age = 0;
            end
            prev_req = puf_req;
            cc = int'(current_count);
            exp_se = (hang < 0) && busy && n_valid && !done && cc >= n_exp && cc < n_exp + int'(ls);
            if (scan_enable !== exp_se) se_bad++;
            if (scan_enable) nscan++;
            if (done) begin
                done_c = c;
                break;
            end
            if (c >= cyc_exp + 20) break;
            start = 1'b0;
            if (r_inject && !injected && busy && n_valid) begin
                start = 1'b1; seed = ~sd; injected = 1'b1;
            end
            if (puf_req && idx < NCH && age == r_dly[idx]) begin
                puf_ack = 1'b1; puf_response = r_rsp[idx];
            end else begin
                puf_ack = 1'b0; puf_response = 16'($urandom);
            end
            if (puf_req) age++;
            step();
            c++;
        end
        start = 1'b0; puf_ack = 1'b0;
        chk({name, ":done_cycle"}, 64'(done_c), 64'(cyc_exp));
        chk({name, ":n_challenges"}, 64'(ncha), 64'(ncha_exp));
        chk({name, ":error"}, 64'(error), 64'(hang >= 0));
        chk({name, ":n_valid"}, 64'(n_valid), 64'(hang < 0));
        chk({name, ":scan_cycles"}, 64'(nscan), 64'(scan_exp));
        chk({name, ":scan_consistency_bad"}, 64'(se_bad), 64'd0);
        if (hang < 0) begin
            chk({name, ":n_auth"}, 64'(n_auth), 64'(n_exp));
            chk({name, ":final_count"}, 64'(current_count), 64'(fin));
        end
        step();
        chk({name, ":after_done"}, {done, busy, scan_enable}, 3'b000);
    endtask

    // Immediate-ack responder for hand-written sequences.
    logic [15:0] h_rsp[NCH];
    int          h_idx;

    task automatic hand_start(input logic [15:0] sd, input logic [15:0] ls);
        start = 1'b1; seed = sd; activation = 4'h9; l_scan = ls;
        step();
        start = 1'b0;
        h_idx = 0;
    endtask

    task automatic hand_step();
        puf_ack = puf_req;
        puf_response = (h_idx < NCH) ? h_rsp[h_idx] : 16'hDEAD;
        step();
        if (puf_ack) h_idx++;
        puf_ack = 1'b0;
    endtask

    typedef struct packed {
        logic [15:0]          seed;
        logic [3:0]           act;
        logic [15:0]          ls;
        logic [NCH-1:0][15:0] rsp;   // element 0 is the rightmost in the concatenation
        logic [NCH-1:0][7:0]  dly;
        logic [15:0]          n_exp;
        logic                 err_exp;
        logic                 inj;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    initial begin
        int dones, r;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed = '0; activation = '0; l_scan = '0;
        puf_ack = 1'b0; puf_response = '0; r_inject = 1'b0; h_idx = 0;
        for (int i = 0; i < NCH; i++) begin r_rsp[i] = '0; r_dly[i] = 0; h_rsp[i] = '0; end

        vecs[0] = '{seed:16'hA5C3, act:4'h5, ls:16'd4, rsp:{16'h0, 16'h0, 16'h1, 16'h3},
                    dly:{8'd0, 8'd0, 8'd0, 8'd0}, n_exp:16'h0002, err_exp:1'b0, inj:1'b1};
        vecs[1] = '{seed:16'h1357, act:4'hA, ls:16'd0, rsp:{16'h0, 16'h0, 16'h1234, 16'h1234},
                    dly:{8'd0, 8'd0, 8'd0, 8'd0}, n_exp:16'h0001, err_exp:1'b0, inj:1'b0};
        vecs[2] = '{seed:16'h0F0F, act:4'h3, ls:16'd3, rsp:{16'h7, 16'h7, 16'h7, 16'h7},
                    dly:{8'd0, 8'd0, 8'd255, 8'd0}, n_exp:16'h0000, err_exp:1'b1, inj:1'b0};
        vecs[3] = '{seed:16'h8001, act:4'hF, ls:16'd2, rsp:{16'h03, 16'h40, 16'h20, 16'h10},
                    dly:{8'd1, 8'd5, 8'd0, 8'd3}, n_exp:16'h0073, err_exp:1'b0, inj:1'b0};
        vecs[4] = '{seed:16'hC0DE, act:4'h1, ls:16'd1, rsp:{16'h0, 16'h0, 16'h0, 16'h5},
                    dly:{8'd0, 8'd0, 8'd0, 8'd63}, n_exp:16'h0005, err_exp:1'b0, inj:1'b0};
        vecs[5] = '{seed:16'hBEEF, act:4'h2, ls:16'd5, rsp:{16'h0, 16'h0, 16'h0, 16'h9},
                    dly:{8'd0, 8'd0, 8'd0, 8'd64}, n_exp:16'h0000, err_exp:1'b1, inj:1'b0};
        vecs[6] = '{seed:16'h0001, act:4'h7, ls:16'd1, rsp:{16'h0, 16'h0, 16'h0, 16'h0},
                    dly:{8'd0, 8'd0, 8'd0, 8'd0}, n_exp:16'h0001, err_exp:1'b0, inj:1'b1};

        step(); step();
        chk_zero("reset_state");
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", {busy, puf_req, done}, 3'b000);

        // Abort while the scan window is open.
        h_rsp[0] = 16'h3; h_rsp[1] = 16'h1; h_rsp[2] = 16'h0; h_rsp[3] = 16'h0;
        hand_start(16'h1111, 16'd4);
        for (int i = 0; i < 60 && !scan_enable; i++) hand_step();
        chk("abort:window_reached", {scan_enable, n_valid}, 2'b11);
        abort = 1'b1;
        hand_step();
        abort = 1'b0;
        chk("abort:outputs", {scan_enable, busy, n_valid, done, puf_req}, 5'b00000);
        dones = 0;
        for (int i = 0; i < 8; i++) begin hand_step(); if (done || busy) dones++; end
        chk("abort:no_done_or_busy", 64'(dones), 64'd0);

        // Abort together with an ack: back to IDLE, no further requests.
        hand_start(16'h2222, 16'd2);
        chk("abort_ack:in_req", puf_req, 1'b1);
        abort = 1'b1; puf_ack = 1'b1; puf_response = 16'hFFFF;
        step();
        abort = 1'b0; puf_ack = 1'b0;
        chk("abort_ack:idle", {busy, puf_req, n_valid}, 3'b000);
        step(); step();
        chk("abort_ack:stays_idle", {busy, puf_req, done}, 3'b000);

        // Reset mid-REQ.
        hand_start(16'h3333, 16'd3);
        chk("rst_req:in_req", {puf_req, puf_activation}, {1'b1, 4'h9});
        rst_n = 1'b0;
        step();
        chk_zero("rst_req:zero");
        rst_n = 1'b1;
        step();
        chk("rst_req:idle", {busy, puf_req}, 2'b00);

        // Reset mid-COUNT.
        hand_start(16'h4444, 16'd6);
        for (int i = 0; i < 40 && !n_valid; i++) hand_step();
        hand_step(); hand_step();
        chk("rst_cnt:in_count", {n_valid, busy, n_auth}, {1'b1, 1'b1, 16'h0002});
        rst_n = 1'b0;
        step();
        chk_zero("rst_cnt:zero");
        rst_n = 1'b1;
        step();

        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < NCH; i++) begin
                r_rsp[i] = vecs[v].rsp[i];
                r_dly[i] = int'(vecs[v].dly[i]);
            end
            r_inject = vecs[v].inj;
            run_auth($sformatf("vec%0d", v), vecs[v].seed, vecs[v].act, vecs[v].ls);
            chk($sformatf("vec%0d:table_error", v), error, vecs[v].err_exp);
            if (!vecs[v].err_exp)
                chk($sformatf("vec%0d:table_n_auth", v), n_auth, vecs[v].n_exp);
        end

        r_inject = 1'b0;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NCH; i++) begin
                r_rsp[i] = 16'($urandom_range(0, 63));
                r = $urandom_range(0, 19);
                r_dly[i] = (r == 0) ? TIMEOUT : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 4);
            end
            r_inject = (t % 3 == 0);
            run_auth($sformatf("rnd%0d", t), 16'($urandom), 4'($urandom),
                     16'($urandom_range(0, 24)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
